// File: rtl/fsic_axis_pkg.sv
// Shared AXI-Stream sideband widths and entry packing layout for FSIC stream FIFOs.
// The layout from the LSB up is tuser, tid, tlast, tkeep, tstrb, tdata.
package fsic_axis_pkg;

  localparam int unsigned TID_W   = 2;
  localparam int unsigned TUSER_W = 2;

  localparam int unsigned OFF_TUSER = 0;
  localparam int unsigned OFF_TID   = OFF_TUSER + TUSER_W;
  localparam int unsigned OFF_TLAST = OFF_TID + TID_W;
  localparam int unsigned OFF_TKEEP = OFF_TLAST + 1;

  function automatic int unsigned off_tstrb(input int unsigned dw);
    return OFF_TKEEP + dw / 8;
  endfunction

  function automatic int unsigned off_tdata(input int unsigned dw);
    return OFF_TKEEP + 2 * (dw / 8);
  endfunction

  function automatic int unsigned entry_w(input int unsigned dw);
    return off_tdata(dw) + dw;
  endfunction

endpackage

// File: rtl/fsic_sync_fifo.sv
// Generic single-clock FIFO storage with wrapping pointers and an occupancy count.
// The read port is first-word-fall-through: rdata always shows mem[rd_ptr].
module fsic_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    count_next
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CW'(1);
    else if (!push && pop)
      count_next = count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fsic_is_rx_fifo.sv
// Receive-side FIFO for the IO serdes stream: absorbs every beat, forwards it downstream,
// and returns a registered flow-control bit that deasserts while free space is low.
module fsic_is_rx_fifo
  import fsic_axis_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH   = 32,
  parameter int unsigned pFIFO_DEPTH   = 16,
  parameter int unsigned pFC_THRESHOLD = 8,
  localparam int unsigned KW = pDATA_WIDTH / 8,
  localparam int unsigned CW = $clog2(pFIFO_DEPTH) + 1
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic [pDATA_WIDTH-1:0] is_as_tdata,
  input  logic [KW-1:0]          is_as_tstrb,
  input  logic [KW-1:0]          is_as_tkeep,
  input  logic                   is_as_tlast,
  input  logic [TID_W-1:0]       is_as_tid,
  input  logic [TUSER_W-1:0]     is_as_tuser,
  input  logic                   is_as_tvalid,
  output logic                   as_is_tready,
  output logic [pDATA_WIDTH-1:0] up_tdata,
  output logic [KW-1:0]          up_tstrb,
  output logic [KW-1:0]          up_tkeep,
  output logic                   up_tlast,
  output logic [TID_W-1:0]       up_tid,
  output logic [TUSER_W-1:0]     up_tuser,
  output logic                   up_tvalid,
  input  logic                   up_tready,
  output logic [CW-1:0]          fifo_count,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam int unsigned EW        = entry_w(pDATA_WIDTH);
  localparam int unsigned OFF_TSTRB = off_tstrb(pDATA_WIDTH);
  localparam int unsigned OFF_TDATA = off_tdata(pDATA_WIDTH);

  logic          push;
  logic          pop;
  logic          drop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;
  logic [CW-1:0] count_next;
  logic [CW-1:0] free_next;

  assign up_tvalid = (fifo_count != '0);
  assign pop       = up_tvalid & up_tready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the beat.
  assign push      = is_as_tvalid & ((fifo_count < CW'(pFIFO_DEPTH)) | pop);
  assign drop      = is_as_tvalid & ~push;

  assign wr_entry = {is_as_tdata, is_as_tstrb, is_as_tkeep, is_as_tlast, is_as_tid, is_as_tuser};

  fsic_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (pFIFO_DEPTH)
  ) u_fifo (
    .clk        (axis_clk),
    .rst_n      (axis_rst_n),
    .push       (push),
    .pop        (pop),
    .wdata      (wr_entry),
    .rdata      (rd_entry),
    .count      (fifo_count),
    .count_next (count_next)
  );

  assign up_tuser = rd_entry[OFF_TUSER +: TUSER_W];
  assign up_tid   = rd_entry[OFF_TID +: TID_W];
  assign up_tlast = rd_entry[OFF_TLAST];
  assign up_tkeep = rd_entry[OFF_TKEEP +: KW];
  assign up_tstrb = rd_entry[OFF_TSTRB +: KW];
  assign up_tdata = rd_entry[OFF_TDATA +: pDATA_WIDTH];

  assign free_next = CW'(pFIFO_DEPTH) - count_next;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      as_is_tready <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      as_is_tready <= (free_next > CW'(pFC_THRESHOLD));
      if (drop)
        overflow <= 1'b1;
      else if (clr_overflow)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fsic_is_rx_fifo.sv
// Directed self-checking bench for fsic_is_rx_fifo at default parameters.
module tb_fsic_is_rx_fifo;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic [31:0] is_as_tdata;
  logic [3:0]  is_as_tstrb;
  logic [3:0]  is_as_tkeep;
  logic        is_as_tlast;
  logic [1:0]  is_as_tid;
  logic [1:0]  is_as_tuser;
  logic        is_as_tvalid;
  logic        as_is_tready;
  logic [31:0] up_tdata;
  logic [3:0]  up_tstrb;
  logic [3:0]  up_tkeep;
  logic        up_tlast;
  logic [1:0]  up_tid;
  logic [1:0]  up_tuser;
  logic        up_tvalid;
  logic        up_tready;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic        clr_overflow;

  int errors = 0;
  int checks = 0;

  always #5 axis_clk = ~axis_clk;

  fsic_is_rx_fifo #(
    .pDATA_WIDTH   (32),
    .pFIFO_DEPTH   (16),
    .pFC_THRESHOLD (8)
  ) dut (
    .axis_clk     (axis_clk),
    .axis_rst_n   (axis_rst_n),
    .is_as_tdata  (is_as_tdata),
    .is_as_tstrb  (is_as_tstrb),
    .is_as_tkeep  (is_as_tkeep),
    .is_as_tlast  (is_as_tlast),
    .is_as_tid    (is_as_tid),
    .is_as_tuser  (is_as_tuser),
    .is_as_tvalid (is_as_tvalid),
    .as_is_tready (as_is_tready),
    .up_tdata     (up_tdata),
    .up_tstrb     (up_tstrb),
    .up_tkeep     (up_tkeep),
    .up_tlast     (up_tlast),
    .up_tid       (up_tid),
    .up_tuser     (up_tuser),
    .up_tvalid    (up_tvalid),
    .up_tready    (up_tready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic last);
    is_as_tdata  = d;
    is_as_tstrb  = 4'hF;
    is_as_tkeep  = 4'hF;
    is_as_tlast  = last;
    is_as_tid    = 2'd0;
    is_as_tuser  = 2'd0;
    is_as_tvalid = 1'b1;
  endtask

  task automatic test_reset();
    axis_rst_n   = 1'b0;
    is_as_tvalid = 1'b0;
    is_as_tdata  = '0;
    is_as_tstrb  = '0;
    is_as_tkeep  = '0;
    is_as_tlast  = 1'b0;
    is_as_tid    = '0;
    is_as_tuser  = '0;
    up_tready    = 1'b0;
    clr_overflow = 1'b0;
    step();
    step();
    checks++; if (as_is_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got=%b exp=0", as_is_tready); end
    checks++; if (up_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", up_tvalid); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    axis_rst_n = 1'b1;
    step();
    checks++; if (as_is_tready !== 1'b1) begin errors++; $display("FAIL release_tready got=%b exp=1", as_is_tready); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL release_count got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_single_beat();
    up_tready    = 1'b1;
    is_as_tdata  = 32'hDEADBEEF;
    is_as_tstrb  = 4'hF;
    is_as_tkeep  = 4'hF;
    is_as_tid    = 2'd2;
    is_as_tuser  = 2'd1;
    is_as_tlast  = 1'b1;
    is_as_tvalid = 1'b1;
    step();
    is_as_tvalid = 1'b0;
    checks++; if (up_tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid got=%b exp=1", up_tvalid); end
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
    checks++;
    if (up_tdata !== 32'hDEADBEEF || up_tstrb !== 4'hF || up_tkeep !== 4'hF ||
        up_tid !== 2'd2 || up_tuser !== 2'd1 || up_tlast !== 1'b1) begin
      errors++;
      $display("FAIL single_fields got=%h/%h/%h/%0d/%0d/%b exp=deadbeef/f/f/2/1/1",
               up_tdata, up_tstrb, up_tkeep, up_tid, up_tuser, up_tlast);
    end
    step();
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL single_drain_count got=%0d exp=0", fifo_count); end
    checks++; if (up_tvalid !== 1'b0) begin errors++; $display("FAIL single_drain_tvalid got=%b exp=0", up_tvalid); end
  endtask

  // Fill to 16 with no pops; tready drops once 8 entries are held.
  task automatic test_flow_fill();
    up_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_beat(32'h100 + 32'(i), 1'b0);
      step();
      checks++;
      if (fifo_count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, fifo_count, i + 1); end
      checks++;
      if (as_is_tready !== ((i + 1) <= 7)) begin errors++; $display("FAIL fill_tready[%0d] got=%b exp=%b", i, as_is_tready, (i + 1) <= 7); end
    end
    is_as_tvalid = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_overflow();
    drive_beat(32'h11111111, 1'b0);
    step();
    is_as_tvalid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", fifo_count); end
    checks++; if (up_tdata !== 32'h100) begin errors++; $display("FAIL ovf_head got=%h exp=00000100", up_tdata); end
    step();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  // Push while full and popping, then drain all 16 in order through the threshold.
  task automatic test_full_push_pop();
    logic [31:0] exp_d;
    up_tready = 1'b1;
    drive_beat(32'hA5A5A5A5, 1'b0);
    step();
    is_as_tvalid = 1'b0;
    up_tready    = 1'b0;
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL pp_count got=%0d exp=16", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow got=%b exp=0", overflow); end
    checks++; if (up_tdata !== 32'h101) begin errors++; $display("FAIL pp_head got=%h exp=00000101", up_tdata); end
    up_tready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp_d = (k < 15) ? (32'h101 + 32'(k)) : 32'hA5A5A5A5;
      checks++;
      if (up_tvalid !== 1'b1 || up_tdata !== exp_d) begin
        errors++; $display("FAIL drain_data[%0d] got=%b/%h exp=1/%h", k, up_tvalid, up_tdata, exp_d);
      end
      step();
      checks++;
      if (fifo_count !== 5'(15 - k)) begin errors++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", k, fifo_count, 15 - k); end
      checks++;
      if (as_is_tready !== ((15 - k) <= 7)) begin errors++; $display("FAIL drain_tready[%0d] got=%b exp=%b", k, as_is_tready, (15 - k) <= 7); end
    end
    up_tready = 1'b0;
    checks++; if (up_tvalid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", up_tvalid); end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int rcvd = 0;
    int cyc  = 0;
    while (rcvd < 40 && cyc < 2000) begin
      up_tready = 1'($urandom_range(0, 1));
      if (up_tvalid && up_tready) begin
        checks++;
        if (up_tdata !== 32'(rcvd) || up_tlast !== ((rcvd % 4) == 3)) begin
          errors++; $display("FAIL wrap_beat[%0d] got=%h/%b exp=%h/%b", rcvd, up_tdata, up_tlast, 32'(rcvd), (rcvd % 4) == 3);
        end
        rcvd++;
      end
      if (sent < 40 && as_is_tready) begin
        drive_beat(32'(sent), (sent % 4) == 3);
        sent++;
      end else begin
        is_as_tvalid = 1'b0;
      end
      step();
      cyc++;
    end
    is_as_tvalid = 1'b0;
    up_tready    = 1'b0;
    checks++; if (rcvd != 40) begin errors++; $display("FAIL wrap_received got=%0d exp=40", rcvd); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_reset_mid();
    up_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(32'h200 + 32'(i), 1'b0);
      step();
    end
    is_as_tvalid = 1'b0;
    checks++; if (fifo_count !== 5'd3) begin errors++; $display("FAIL mid_precount got=%0d exp=3", fifo_count); end
    #2;
    axis_rst_n = 1'b0;
    #1;
    checks++;
    if (up_tvalid !== 1'b0 || fifo_count !== 5'd0 || as_is_tready !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL mid_reset got=%b/%0d/%b/%b exp=0/0/0/0", up_tvalid, fifo_count, as_is_tready, overflow);
    end
    step();
    axis_rst_n = 1'b1;
    step();
    checks++;
    if (as_is_tready !== 1'b1 || fifo_count !== 5'd0 || up_tvalid !== 1'b0) begin
      errors++; $display("FAIL mid_release got=%b/%0d/%b exp=1/0/0", as_is_tready, fifo_count, up_tvalid);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_flow_fill();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
